ieeedrv_sd_arb: RTL and testbench
=================================

Name: ieeedrv_sd_arb

Overview: Schedules block transfers between the SUBDRV sub-drive track buffers of the IEEE drive and the single MiSTer SD block channel. Each sub-drive posts read (load) or write (save) requests with an LBA. The arbiter grants one request at a time in round-robin order, drives the SD handshake, and routes the sd_buff byte stream to or from the granted drive. It sits between the per-drive mechanism/track-buffer logic and hps_io.

Parameters:
SUBDRV, 2, number of sub-drives (1 or 2); NS = SUBDRV-1
BLK_CNT, 6'd0, value driven on sd_blk_cnt (0 = 1 block of 512 bytes)
TIMEOUT, 24'hFFFFFF, clk_sys cycles to wait for sd_ack rise before aborting

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high
img_mounted  in  SUBDRV  per-drive mount pulse; flushes that drive's pending requests
req_rd  in  SUBDRV  one-cycle pulse: load block for drive i
req_wr  in  SUBDRV  one-cycle pulse: save block for drive i
req_lba  in  32 x SUBDRV (unpacked [SUBDRV])  LBA for drive i, sampled with its req pulse
busy  out  SUBDRV  drive i has a pending or active request
done  out  SUBDRV  one-cycle pulse: drive i transfer finished
err  out  SUBDRV  one-cycle pulse: drive i transfer aborted on timeout
sd_lba  out  32  LBA to hps_io
sd_blk_cnt  out  6  constant BLK_CNT
sd_rd  out  1  read request to hps_io
sd_wr  out  1  write request to hps_io
sd_ack  in  1  hps_io transfer acknowledge
sd_buff_addr  in  9  byte address from hps_io
sd_buff_dout  in  8  byte from SD (read)
sd_buff_wr  in  1  byte strobe from hps_io
sd_buff_din  out  8  byte to SD (write), muxed from granted drive
buf_addr  out  9  registered copy of sd_buff_addr, to all drives
buf_dout  out  8  registered copy of sd_buff_dout, to all drives
buf_we  out  SUBDRV  write strobe, only the granted drive, only on reads
buf_din  in  8 x SUBDRV  per-drive buffer read data

Behaviour:
- Reset: all outputs 0, pending flags cleared, round-robin pointer = 0, state IDLE. Reset mid-transfer drops sd_rd/sd_wr the same cycle. No done/err is issued.
- Pending: per drive, pend_rd, pend_wr and lba[i]. A req pulse sets the flag and latches req_lba.
  - A repeat request while a flag is set overwrites lba[i] (last wins).
  - req_rd and req_wr in the same cycle: both flags set.
  - img_mounted[i] clears both flags for drive i. If drive i is active, the transfer completes, but done[i] is suppressed.
- busy[i] = pend_rd | pend_wr | (active and grant==i).
- Selection in IDLE: scan drives from the pointer upward with wrap; the first drive with any flag wins.
  - Within a drive, write beats read, so a dirty buffer is saved before a reload.
  - Winner's flag clears; grant, op and sd_lba are registered; pointer = grant+1 mod SUBDRV.
- FSM:
  - IDLE -> ISSUE when any flag is set (1 cycle to select).
  - ISSUE: hold sd_rd or sd_wr high and count cycles. Go to XFER on sd_ack=1, dropping sd_rd/sd_wr the same cycle. If the count reaches TIMEOUT, drop the request, pulse err[grant], and go to IDLE.
  - XFER: while sd_ack=1, route bytes. Go to DONE on sd_ack 1->0.
  - DONE: pulse done[grant] for 1 cycle -> IDLE. Minimum gap between back-to-back grants is 2 cycles.
- Routing, registered with 1-cycle latency:
  - buf_addr <= sd_buff_addr; buf_dout <= sd_buff_dout.
  - buf_we[grant] <= sd_buff_wr & op==RD & state==XFER; all other bits 0.
  - sd_buff_din = buf_din[grant], combinational, so hps_io sees data for the current address on a read.
- Strobes outside XFER or on write ops never reach buf_we.
- sd_lba and grant are stable from ISSUE through DONE.

Test Plan:
- Single read, drive 0, LBA 0x0000_0123: sd_rd=1 and sd_lba=0x123 until ack. 512 strobes with data=addr[7:0] -> buf_we[0] 512 times, buf_we[1]=0, one cycle behind. done[0] pulses once after ack falls; busy[0] drops.
- Write from drive 1: buf_din[1]=~addr[7:0] -> sd_wr=1 and sd_buff_din=~sd_buff_addr[7:0] during ack; no buf_we pulses; done[1] pulses.
- Fairness: req_rd to both drives in the same cycle with pointer 0 -> drive 0 is served, then drive 1. A drive 0 re-request during drive 1's transfer is served after drive 1.
- Same-drive rd+wr pulse with LBAs 5 then 5 -> sd_wr is issued first, then sd_rd; two done pulses in total.
- Timeout: TIMEOUT=100, never ack -> sd_rd drops after 100 cycles, err[0] pulses, done[0] stays 0, and the next pending request is served.
- Reset asserted mid-XFER and img_mounted[1] during a pending request -> sd_rd/wr, busy and buf_we all go to 0 immediately; no done pulses follow.

Source files
------------

// File: rtl/ieeedrv_sd_arb.sv
`default_nettype none
// ============================================================================
// ieeedrv_sd_arb : round-robin arbiter of sub-drive block transfers onto the
//                  single SD block channel of hps_io.          Revision: 1.0
// ============================================================================
module ieeedrv_sd_arb #(
  parameter int          SUBDRV  = 2,
  parameter logic [5:0]  BLK_CNT = 6'd0,
  parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [SUBDRV-1:0] img_mounted_i,
  input  logic [SUBDRV-1:0] req_rd_i,
  input  logic [SUBDRV-1:0] req_wr_i,
  input  logic [31:0]       req_lba_i [SUBDRV],
  output logic [SUBDRV-1:0] busy_o,
  output logic [SUBDRV-1:0] done_o,
  output logic [SUBDRV-1:0] err_o,
  output logic [31:0]       sd_lba_o,
  output logic [5:0]        sd_blk_cnt_o,
  output logic              sd_rd_o,
  output logic              sd_wr_o,
  input  logic              sd_ack_i,
  input  logic [8:0]        sd_buff_addr_i,
  input  logic [7:0]        sd_buff_dout_i,
  input  logic              sd_buff_wr_i,
  output logic [7:0]        sd_buff_din_o,
  output logic [8:0]        buf_addr_o,
  output logic [7:0]        buf_dout_o,
  output logic [SUBDRV-1:0] buf_we_o,
  input  logic [7:0]        buf_din_i [SUBDRV]
);

  localparam int            PW      = (SUBDRV > 1) ? $clog2(SUBDRV) : 1;
  localparam logic [PW-1:0] NS      = PW'(SUBDRV - 1);
  localparam logic [23:0]   TO_LAST = TIMEOUT - 24'd1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [SUBDRV-1:0] pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
  logic [31:0]       lba_q [SUBDRV];
  logic [31:0]       lba_d [SUBDRV];
  logic [PW-1:0]     ptr_q, ptr_d, grant_q, grant_d;
  logic              op_wr_q, op_wr_d;
  logic [31:0]       sd_lba_q, sd_lba_d;
  logic              sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
  logic [23:0]       cnt_q, cnt_d;
  logic [SUBDRV-1:0] err_q, err_d;
  logic              supp_q, supp_d;
  logic [8:0]        buf_addr_q;
  logic [7:0]        buf_dout_q;
  logic [SUBDRV-1:0] buf_we_q;

  logic              w_found;
  logic [PW-1:0]     w_win, w_idx;
  logic [SUBDRV-1:0] w_gnt_oh;

  // First drive with any pending flag, scanning upward from the pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < SUBDRV; k++) begin
      w_idx = PW'((int'(ptr_q) + k) % SUBDRV);
      if (!w_found && (pend_rd_q[w_idx] | pend_wr_q[w_idx])) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_gnt_oh = '0;
    for (int i = 0; i < SUBDRV; i++) begin
      w_gnt_oh[i] = (grant_q == PW'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    pend_wr_d = pend_wr_q;
    lba_d     = lba_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    op_wr_d   = op_wr_q;
    sd_lba_d  = sd_lba_q;
    sd_rd_d   = sd_rd_q;
    sd_wr_d   = sd_wr_q;
    cnt_d     = cnt_q;
    err_d     = '0;
    supp_d    = supp_q;

    case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          grant_d  = w_win;
          op_wr_d  = pend_wr_q[w_win];
          sd_lba_d = lba_q[w_win];
          sd_wr_d  = pend_wr_q[w_win];
          sd_rd_d  = ~pend_wr_q[w_win];
          // A dirty buffer is saved before any reload of the same drive.
          if (pend_wr_q[w_win]) pend_wr_d[w_win] = 1'b0;
          else                  pend_rd_d[w_win] = 1'b0;
          ptr_d    = (w_win == NS) ? '0 : w_win + 1'b1;
          cnt_d    = '0;
          supp_d   = 1'b0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (sd_ack_i) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = ST_XFER;
        end else if (cnt_q == TO_LAST) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          err_d   = w_gnt_oh;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ST_XFER: if (!sd_ack_i) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    // New requests land after the winner's flag is cleared so none is lost.
    for (int i = 0; i < SUBDRV; i++) begin
      if (img_mounted_i[i]) begin
        pend_rd_d[i] = 1'b0;
        pend_wr_d[i] = 1'b0;
        if (state_q != ST_IDLE && grant_q == PW'(i)) supp_d = 1'b1;
      end else begin
        if (req_rd_i[i]) pend_rd_d[i] = 1'b1;
        if (req_wr_i[i]) pend_wr_d[i] = 1'b1;
        if (req_rd_i[i] | req_wr_i[i]) lba_d[i] = req_lba_i[i];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pend_rd_q  <= '0;
      pend_wr_q  <= '0;
      lba_q      <= '{default: '0};
      ptr_q      <= '0;
      grant_q    <= '0;
      op_wr_q    <= 1'b0;
      sd_lba_q   <= '0;
      sd_rd_q    <= 1'b0;
      sd_wr_q    <= 1'b0;
      cnt_q      <= '0;
      err_q      <= '0;
      supp_q     <= 1'b0;
      buf_addr_q <= '0;
      buf_dout_q <= '0;
      buf_we_q   <= '0;
    end else begin
      state_q    <= state_d;
      pend_rd_q  <= pend_rd_d;
      pend_wr_q  <= pend_wr_d;
      lba_q      <= lba_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      op_wr_q    <= op_wr_d;
      sd_lba_q   <= sd_lba_d;
      sd_rd_q    <= sd_rd_d;
      sd_wr_q    <= sd_wr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      supp_q     <= supp_d;
      buf_addr_q <= sd_buff_addr_i;
      buf_dout_q <= sd_buff_dout_i;
      buf_we_q   <= w_gnt_oh & {SUBDRV{sd_buff_wr_i & ~op_wr_q & (state_q == ST_XFER)}};
    end
  end

  // Handshake, busy and strobes are gated by reset so they fall in the reset cycle.
  assign sd_rd_o       = sd_rd_q & ~reset;
  assign sd_wr_o       = sd_wr_q & ~reset;
  assign busy_o        = reset ? '0 :
                         (pend_rd_q | pend_wr_q | ((state_q != ST_IDLE) ? w_gnt_oh : '0));
  assign done_o        = (state_q == ST_DONE && !supp_q && !reset) ? w_gnt_oh : '0;
  assign err_o         = err_q;
  assign sd_lba_o      = sd_lba_q;
  assign sd_blk_cnt_o  = BLK_CNT;
  assign sd_buff_din_o = reset ? 8'h00 : buf_din_i[grant_q];
  assign buf_addr_o    = buf_addr_q;
  assign buf_dout_o    = buf_dout_q;
  assign buf_we_o      = reset ? '0 : buf_we_q;

endmodule
`default_nettype wire

// File: tb/tb_ieeedrv_sd_arb.sv
`default_nettype none
// ============================================================================
// tb_ieeedrv_sd_arb : directed bench for ieeedrv_sd_arb with a simple hps_io
//                     transfer model.                           Revision: 1.0
// ============================================================================
module tb_ieeedrv_sd_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mnt, rrd, rwr;
  logic [31:0] lba [2];
  logic [1:0]  busy, done, err;
  logic [31:0] sd_lba;
  logic [5:0]  blk;
  logic        sd_rd, sd_wr, ack, bwr;
  logic [8:0]  addr, baddr;
  logic [7:0]  dout, din_o, bdout;
  logic [1:0]  bwe;
  logic [7:0]  bdin [2];

  int vec = 0, miss = 0;
  int we0 = 0, we1 = 0, d0 = 0, d1 = 0, e0 = 0, e1 = 0, wd_bad = 0;
  int din_bad = 0;
  int n;

  always #5 clk = ~clk;

  ieeedrv_sd_arb #(.SUBDRV(2), .BLK_CNT(6'd0), .TIMEOUT(24'd100)) dut (
    .clk_sys(clk), .reset(rst),
    .img_mounted_i(mnt), .req_rd_i(rrd), .req_wr_i(rwr), .req_lba_i(lba),
    .busy_o(busy), .done_o(done), .err_o(err),
    .sd_lba_o(sd_lba), .sd_blk_cnt_o(blk), .sd_rd_o(sd_rd), .sd_wr_o(sd_wr),
    .sd_ack_i(ack), .sd_buff_addr_i(addr), .sd_buff_dout_i(dout),
    .sd_buff_wr_i(bwr), .sd_buff_din_o(din_o),
    .buf_addr_o(baddr), .buf_dout_o(bdout), .buf_we_o(bwe), .buf_din_i(bdin)
  );

  // Drive buffers: drive 0 returns addr[7:0], drive 1 returns its inverse.
  always_comb begin
    bdin[0] = addr[7:0];
    bdin[1] = ~addr[7:0];
  end

  always @(negedge clk) begin
    if (bwe[0]) we0++;
    if (bwe[1]) we1++;
    if (bwe != 2'b00 && bdout !== baddr[7:0]) wd_bad++;
    if (done[0]) d0++;
    if (done[1]) d1++;
    if (err[0]) e0++;
    if (err[1]) e1++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(output int cnt);
    cnt = 0;
    while (!(sd_rd | sd_wr) && cnt < 50) begin
      tick();
      cnt++;
    end
    chk("req_seen", {31'd0, sd_rd | sd_wr}, 32'd1);
  endtask

  // hps_io side: ack, 512 bytes with data = addr[7:0], then ack falls.
  task automatic hps(input logic strobe, input logic chk_din);
    logic [7:0] av;
    ack = 1'b1;
    tick();
    chk("req_drop", {30'd0, sd_rd, sd_wr}, 32'd0);
    for (int a = 0; a < 512; a++) begin
      addr = 9'(a);
      av   = 8'(a);
      dout = av;
      bwr  = strobe;
      #1;
      if (chk_din && din_o !== ~av) din_bad++;
      tick();
    end
    bwr = 1'b0;
    tick();
    ack = 1'b0;
  endtask

  task automatic finish_xfer(input logic [1:0] exp_done);
    tick();
    chk("done_pulse", {30'd0, done}, {30'd0, exp_done});
  endtask

  initial begin
    rst = 1'b1; mnt = 2'b00; rrd = 2'b00; rwr = 2'b00;
    lba[0] = '0; lba[1] = '0;
    ack = 1'b0; bwr = 1'b0; addr = '0; dout = '0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_busy", {30'd0, busy}, 32'd0);
    chk("rst_done_err", {28'd0, done, err}, 32'd0);
    chk("rst_rdwr", {30'd0, sd_rd, sd_wr}, 32'd0);
    chk("rst_lba", sd_lba, 32'd0);
    chk("rst_bwe_blk", {24'd0, bwe, blk}, 32'd0);
    rst = 1'b0;
    tick();

    // Single read, drive 0
    lba[0] = 32'h0000_0123; rrd = 2'b01;
    tick();
    rrd = 2'b00;
    chk("rd0_busy", {30'd0, busy}, 32'd1);
    chk("rd0_idle_rd", {31'd0, sd_rd}, 32'd0);
    tick();
    chk("rd0_rd", {30'd0, sd_rd, sd_wr}, 32'd2);
    chk("rd0_lba", sd_lba, 32'h123);
    tick(); tick(); tick();
    chk("rd0_hold", {30'd0, sd_rd, sd_wr}, 32'd2);
    hps(1'b1, 1'b0);
    finish_xfer(2'b01);
    chk("rd0_busy_done", {30'd0, busy}, 32'd1);
    tick();
    chk("rd0_busy_off", {30'd0, busy}, 32'd0);
    chk("rd0_we0", we0, 512);
    chk("rd0_we1", we1, 0);
    chk("rd0_data", wd_bad, 0);
    chk("rd0_dcnt", d0, 1);

    // Write from drive 1
    lba[1] = 32'h0000_0456; rwr = 2'b10;
    tick();
    rwr = 2'b00;
    wait_req(n);
    chk("wr1_wr", {30'd0, sd_rd, sd_wr}, 32'd1);
    chk("wr1_lba", sd_lba, 32'h456);
    hps(1'b1, 1'b1);
    finish_xfer(2'b10);
    chk("wr1_din", din_bad, 0);
    chk("wr1_no_we", we0 + we1, 512);
    tick();

    // Fairness: both drives at once from pointer 0
    lba[0] = 32'h10; lba[1] = 32'h20; rrd = 2'b11;
    tick();
    rrd = 2'b00;
    chk("rr_busy", {30'd0, busy}, 32'd3);
    wait_req(n);
    chk("rr_first", sd_lba, 32'h10);
    hps(1'b1, 1'b0);
    finish_xfer(2'b01);
    wait_req(n);
    chk("rr_gap", n, 2);
    chk("rr_second", sd_lba, 32'h20);
    lba[0] = 32'h30; rrd = 2'b01;
    tick();
    rrd = 2'b00;
    hps(1'b1, 1'b0);
    finish_xfer(2'b10);
    wait_req(n);
    chk("rr_third", sd_lba, 32'h30);
    hps(1'b1, 1'b0);
    finish_xfer(2'b01);
    tick();
    chk("rr_we", {we0[15:0], we1[15:0]}, {16'd1536, 16'd512});
    chk("rr_dcnt", {d0[15:0], d1[15:0]}, {16'd3, 16'd2});

    // Same-drive read+write in one cycle: write first
    lba[0] = 32'd5; rrd = 2'b01; rwr = 2'b01;
    tick();
    rrd = 2'b00; rwr = 2'b00;
    wait_req(n);
    chk("rw_first_wr", {30'd0, sd_rd, sd_wr}, 32'd1);
    chk("rw_lba_a", sd_lba, 32'd5);
    hps(1'b1, 1'b0);
    finish_xfer(2'b01);
    wait_req(n);
    chk("rw_then_rd", {30'd0, sd_rd, sd_wr}, 32'd2);
    chk("rw_lba_b", sd_lba, 32'd5);
    hps(1'b1, 1'b0);
    finish_xfer(2'b01);
    tick();
    chk("rw_we0", we0, 2048);
    chk("rw_dcnt", d0, 5);

    // Timeout on drive 0, drive 1 queued behind it
    lba[0] = 32'h77; rrd = 2'b01;
    tick();
    rrd = 2'b00;
    wait_req(n);
    chk("to_lba", sd_lba, 32'h77);
    lba[1] = 32'h99; rrd = 2'b10;
    n = 0;
    while (sd_rd && n < 300) begin
      tick();
      rrd = 2'b00;
      n++;
    end
    chk("to_cycles", n, 100);
    chk("to_err", {30'd0, err}, 32'd1);
    chk("to_no_done", {30'd0, done}, 32'd0);
    wait_req(n);
    chk("to_next_lba", sd_lba, 32'h99);
    hps(1'b1, 1'b0);
    finish_xfer(2'b10);
    tick();
    chk("to_counts", {e0[7:0], e1[7:0], d0[7:0], d1[7:0]}, {8'd1, 8'd0, 8'd5, 8'd3});

    // Mount of the active drive: transfer completes, done suppressed
    lba[0] = 32'h40; rrd = 2'b01;
    tick();
    rrd = 2'b00;
    wait_req(n);
    ack = 1'b1; mnt = 2'b01;
    tick();
    mnt = 2'b00;
    chk("mnt_busy", {30'd0, busy}, 32'd1);
    for (int a = 0; a < 4; a++) begin
      addr = 9'(a); dout = 8'(a); bwr = 1'b1;
      tick();
    end
    bwr = 1'b0; ack = 1'b0;
    tick();
    chk("mnt_no_done", {30'd0, done}, 32'd0);
    tick();
    chk("mnt_busy_off", {30'd0, busy}, 32'd0);
    chk("mnt_dcnt", d0, 5);

    // Reset mid-XFER with a flushed pending request on drive 1
    lba[0] = 32'h200; rrd = 2'b01;
    tick();
    rrd = 2'b00;
    wait_req(n);
    ack = 1'b1;
    tick();
    lba[1] = 32'h300; rwr = 2'b10; bwr = 1'b1; addr = 9'd0; dout = 8'd0;
    tick();
    rwr = 2'b00;
    chk("rx_busy_both", {30'd0, busy}, 32'd3);
    mnt = 2'b10; addr = 9'd1; dout = 8'd1;
    tick();
    mnt = 2'b00;
    chk("rx_busy_flush", {30'd0, busy}, 32'd1);
    chk("rx_bwe", {30'd0, bwe}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rx_imm", {26'd0, sd_rd, sd_wr, busy, bwe}, 32'd0);
    tick();
    rst = 1'b0; bwr = 1'b0; ack = 1'b0;
    chk("rx_after", {26'd0, sd_rd, sd_wr, busy, bwe}, 32'd0);
    repeat (10) tick();
    chk("rx_quiet", {29'd0, sd_rd, sd_wr, |busy}, 32'd0);
    chk("rx_dcnt", {d0[15:0], d1[15:0]}, {16'd5, 16'd3});
    chk("rx_data", wd_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
`default_nettype wire
